// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared widths, FSM states and address-range helper for the data-memory responder
package riscv_mem_pkg;
  localparam int XLEN = 32;
  localparam int BE_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;
  function automatic logic addr_in_range(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] base,
                                         input int unsigned depth_words);
    logic [XLEN-1:0] off;
    off = addr - base;
    return off < XLEN'(depth_words << 2);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-organised storage with per-byte write enables and a registered read port
module dmem_array
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic            i_re,
  input  logic [AW-1:0]   i_idx,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [BE_W-1:0] i_be,
  output logic [XLEN-1:0] o_rdata
);
  logic [XLEN-1:0] r_mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++)
      if (i_we && i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
    if (i_re) o_rdata <= r_mem[i_idx];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data memory with programmable wait states between accept and response
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter int unsigned     LATENCY     = 2,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_2000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [BE_W-1:0] req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  dmem_state_e     r_state;
  logic [3:0]      r_cnt;
  logic            r_we, r_rd_ok;
  logic [XLEN-1:0] r_addr, r_wdata;
  logic [BE_W-1:0] r_be;
  logic            w_idle, w_we, w_err, w_commit;
  logic [XLEN-1:0] w_addr, w_wdata, w_rdata;
  logic [BE_W-1:0] w_be;
  logic [AW-1:0]   w_idx;
  // In IDLE the live request feeds the array so a zero-latency build can commit on the accept edge
  assign w_idle   = r_state == IDLE;
  assign w_we     = w_idle ? req_we    : r_we;
  assign w_addr   = w_idle ? req_addr  : r_addr;
  assign w_wdata  = w_idle ? req_wdata : r_wdata;
  assign w_be     = w_idle ? req_be    : r_be;
  assign w_idx    = AW'((w_addr - BASE_ADDR) >> 2);
  assign w_err    = (w_addr[1:0] != 2'b00) || !addr_in_range(w_addr, BASE_ADDR, DEPTH_WORDS);
  assign w_commit = rst_n && ((r_state == WAIT && r_cnt == 4'd0) || (LATENCY == 0 && w_idle && req_valid));
  assign rsp_rdata = r_rd_ok ? w_rdata : '0;
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk    (clk),
    .i_we   (w_commit && w_we && !w_err),
    .i_re   (w_commit && !w_we && !w_err),
    .i_idx  (w_idx),
    .i_wdata(w_wdata),
    .i_be   (w_be),
    .o_rdata(w_rdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      r_rd_ok   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_we      <= req_we;
          r_addr    <= req_addr;
          r_wdata   <= req_wdata;
          r_be      <= req_be;
          req_ready <= 1'b0;
          r_state   <= WAIT;
          r_cnt     <= 4'(LATENCY - 1);
        end
        WAIT: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        RESP: if (rsp_ready) begin
          r_state   <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          r_rd_ok   <= 1'b0;
          req_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
      // Entering RESP overrides the per-state update above
      if (w_commit) begin
        r_state   <= RESP;
        rsp_valid <= 1'b1;
        rsp_err   <= w_err;
        r_rd_ok   <= !w_we && !w_err;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a word-array model
module tb_dmem_responder;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int          LAT   = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_be = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic z_req_valid = 1'b0, z_req_we = 1'b0, z_rsp_ready = 1'b0;
  logic [31:0] z_req_addr = '0, z_req_wdata = '0;
  logic [3:0] z_req_be = '0;
  logic z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;
  int total = 0, bad = 0;
  logic [31:0] model [16];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be), .rsp_valid(z_rsp_valid),
    .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err));

  // Drives one transaction on the LATENCY=2 instance; ok collects handshake/stability observations
  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     input int hold, output logic [31:0] rd, output logic er, output int lat, output logic ok);
    @(negedge clk);
    ok = req_ready;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 40);
    rd = rsp_rdata; er = rsp_err;
    ok = ok && rsp_valid && !req_ready;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      ok = ok && rsp_valid && rsp_rdata === rd && rsp_err === er && !req_ready;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    ok = ok && !rsp_valid && req_ready;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
    total++; if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_lat0: got ready=%b valid=%b want 1/0", z_req_ready, z_rsp_valid); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [31:0] rd; logic er, ok; int lat;
    txn(1'b1, BASE, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, ok);
    total++; if (lat != LAT + 1) begin bad++; $display("FAIL basic_wr_lat: got %0d want %0d", lat, LAT + 1); end
    total++; if (er !== 1'b0 || rd !== 32'h0 || !ok) begin bad++; $display("FAIL basic_wr_rsp: got err=%b rd=%h ok=%b want 0/0/1", er, rd, ok); end
    txn(1'b0, BASE, 32'h0, 4'h0, 0, rd, er, lat, ok);
    total++; if (lat != LAT + 1) begin bad++; $display("FAIL basic_rd_lat: got %0d want %0d", lat, LAT + 1); end
    total++; if (rd !== 32'hDEADBEEF || er !== 1'b0 || !ok) begin bad++; $display("FAIL basic_rd: got %h err=%b ok=%b want deadbeef/0/1", rd, er, ok); end
  endtask

  task automatic test_partial;
    logic [31:0] rd; logic er, ok; int lat;
    txn(1'b1, BASE, 32'h0000AA00, 4'b0010, 0, rd, er, lat, ok);
    txn(1'b0, BASE, 32'h0, 4'h0, 0, rd, er, lat, ok);
    total++; if (rd !== 32'hDEADAAEF || er !== 1'b0) begin bad++; $display("FAIL partial_rd: got %h want deadaaef", rd); end
    txn(1'b1, BASE, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat, ok);
    total++; if (lat != LAT + 1 || er !== 1'b0 || !ok) begin bad++; $display("FAIL be0_ack: got lat=%0d err=%b ok=%b want %0d/0/1", lat, er, ok, LAT + 1); end
    txn(1'b0, BASE, 32'h0, 4'h0, 0, rd, er, lat, ok);
    total++; if (rd !== 32'hDEADAAEF) begin bad++; $display("FAIL be0_noop: got %h want deadaaef", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er, ok; int lat;
    txn(1'b0, BASE + 2, 32'h0, 4'hF, 0, rd, er, lat, ok);
    total++; if (er !== 1'b1 || rd !== 32'h0 || lat != LAT + 1) begin bad++; $display("FAIL err_misalign: got err=%b rd=%h lat=%0d want 1/0/%0d", er, rd, lat, LAT + 1); end
    txn(1'b0, BASE + DEPTH * 4, 32'h0, 4'hF, 0, rd, er, lat, ok);
    total++; if (er !== 1'b1 || rd !== 32'h0 || lat != LAT + 1) begin bad++; $display("FAIL err_range: got err=%b rd=%h lat=%0d want 1/0/%0d", er, rd, lat, LAT + 1); end
    txn(1'b1, BASE + DEPTH * 4, 32'h11111111, 4'hF, 0, rd, er, lat, ok);
    txn(1'b1, BASE + 1, 32'h22222222, 4'hF, 0, rd, er, lat, ok);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_wr: got err=%b want 1", er); end
    txn(1'b0, BASE, 32'h0, 4'h0, 0, rd, er, lat, ok);
    total++; if (rd !== 32'hDEADAAEF || er !== 1'b0) begin bad++; $display("FAIL err_nowrite: got %h want deadaaef", rd); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic er, ok, stable; int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = BASE; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = BASE + 8; req_wdata = 32'h55AA55AA; req_be = 4'hF;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
    rd = rsp_rdata; stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stable = stable && rsp_valid && rsp_rdata === rd && !req_ready;
    end
    total++; if (n != LAT + 1 || rd !== 32'hDEADAAEF) begin bad++; $display("FAIL bp_rd: got lat=%0d rd=%h want %0d/deadaaef", n, rd, LAT + 1); end
    total++; if (!stable) begin bad++; $display("FAIL bp_stable: got unstable response want stable"); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_second_accept: got ready=%b want 0", req_ready); end
    req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    txn(1'b0, BASE + 8, 32'h0, 4'h0, 0, rd, er, n, ok);
    total++; if (rd !== 32'h55AA55AA) begin bad++; $display("FAIL bp_held_write: got %h want 55aa55aa", rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er, ok; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 4; req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL mid_reset_outputs: got ready=%b valid=%b err=%b rd=%h want 1/0/0/0", req_ready, rsp_valid, rsp_err, rsp_rdata); end
    @(negedge clk); rst_n = 1'b1;
    txn(1'b0, BASE + 4, 32'h0, 4'h0, 0, rd, er, lat, ok);
    total++; if (rd === 32'h12345678 || er !== 1'b0) begin bad++; $display("FAIL mid_reset_discard: got %h err=%b want not 12345678", rd, er); end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, d, exp; logic er, ok, exp_err, we; logic [3:0] be; int lat, k, idx, hold;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      txn(1'b1, BASE + 32'(4 * i), model[i], 4'hF, 0, rd, er, lat, ok);
    end
    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 9); idx = $urandom_range(0, 15);
      we = 1'($urandom); d = $urandom; be = 4'($urandom); hold = $urandom_range(0, 3);
      a = k < 7 ? BASE + 32'(4 * idx) : k == 7 ? BASE + 32'(4 * idx) + 32'($urandom_range(1, 3))
        : k == 8 ? BASE + 32'(DEPTH * 4 + 4 * idx) : BASE - 32'(4 + 4 * idx);
      exp_err = k >= 7;
      exp = (we || exp_err) ? 32'h0 : model[idx];
      if (we && !exp_err) for (int b = 0; b < 4; b++) if (be[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      txn(we, a, d, be, hold, rd, er, lat, ok);
      total++; if (lat != LAT + 1) begin bad++; $display("FAIL rnd_lat t=%0d: got %0d want %0d", t, lat, LAT + 1); end
      total++; if (er !== exp_err) begin bad++; $display("FAIL rnd_err t=%0d addr=%h: got %b want %b", t, a, er, exp_err); end
      total++; if (rd !== exp) begin bad++; $display("FAIL rnd_rdata t=%0d addr=%h we=%b: got %h want %h", t, a, we, rd, exp); end
      total++; if (!ok) begin bad++; $display("FAIL rnd_handshake t=%0d: got unstable/bad handshake want clean", t); end
    end
  endtask

  task automatic test_lat0;
    logic [31:0] wd [4]; logic [31:0] got [4]; logic errs;
    int sent, done, first_acc, last_hs, acc_edge, lat_bad;
    for (int i = 0; i < 4; i++) wd[i] = $urandom;
    for (int ph = 0; ph < 2; ph++) begin
      sent = 0; done = 0; first_acc = -1; last_hs = -1; acc_edge = -10; lat_bad = 0; errs = 1'b0;
      z_rsp_ready = 1'b1;
      for (int e = 0; e < 40 && done < 4; e++) begin
        @(negedge clk);
        if (z_rsp_valid) begin
          got[done] = z_rsp_rdata; errs = errs | z_rsp_err;
          if (e != acc_edge + 1) lat_bad++;
          done++; last_hs = e;
        end
        z_req_valid = z_req_ready && sent < 4;
        if (z_req_valid) begin
          z_req_we = (ph == 0); z_req_addr = BASE + 32'h40 + 32'(4 * sent); z_req_wdata = wd[sent]; z_req_be = 4'hF;
          if (first_acc < 0) first_acc = e;
          acc_edge = e; sent++;
        end
      end
      @(posedge clk); #1;
      z_req_valid = 1'b0; z_rsp_ready = 1'b0;
      total++; if (done != 4 || last_hs - first_acc + 1 != 8) begin bad++; $display("FAIL lat0_throughput ph=%0d: got done=%0d span=%0d want 4/8", ph, done, last_hs - first_acc + 1); end
      total++; if (lat_bad != 0 || errs !== 1'b0) begin bad++; $display("FAIL lat0_latency ph=%0d: got late=%0d err=%b want 0/0", ph, lat_bad, errs); end
      for (int i = 0; i < 4; i++) begin
        total++; if (got[i] !== (ph == 0 ? 32'h0 : wd[i])) begin bad++; $display("FAIL lat0_data ph=%0d i=%0d: got %h want %h", ph, i, got[i], ph == 0 ? 32'h0 : wd[i]); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_partial;
    test_errors;
    test_backpressure;
    test_reset_mid;
    test_random;
    test_lat0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
